// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the chunk-serial adder: FSM encoding and counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multi_cycle_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Chunk counter width; a single-chunk adder still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full adders.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: x_i/y_i operands, ci_i carry in; sum_o result, co_o carry out of the
//        top bit, c_msb_in_o carry into the top bit (used for signed overflow).
module full_adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x_i,
  input  logic [CHUNK-1:0] y_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  // Each bit owns its carry-in/carry-out nets so the ripple is a chain of
  // distinct signals rather than a vector feeding back into itself.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_first
      assign c_in = ci_i;
    end else begin : g_next
      assign c_in = g_bit[i-1].c_out;
    end

    assign sum_o[i] = x_i[i] ^ y_i[i] ^ c_in;
    assign c_out    = (x_i[i] & y_i[i]) | (c_in & (x_i[i] ^ y_i[i]));
  end

  assign co_o       = g_bit[CHUNK-1].c_out;
  assign c_msb_in_o = g_bit[CHUNK-1].c_in;

endmodule

// File: rtl/multi_cycle_adder.sv
// Chunk-serial two's-complement adder/subtractor with start/done handshake.
// Latency: WIDTH/CHUNK cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; no queuing, done is a 1-cycle pulse.
// Ports: clk_i/rst_i (sync, active-high); start_i, sub_i, a_i, b_i, cin_i request;
//        busy_o in flight, done_o result valid, s_o/cout_o/ovf_o registered result.
module multi_cycle_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = cnt_width(N);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("multi_cycle_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_sum;
  logic             chunk_co, chunk_cmsb;
  logic [WIDTH-1:0] sum_ext, sum_pos;

  // Bring the active chunk down to bit 0 and place its sum back in position.
  always_comb begin
    shamt   = 32'(idx_q) * 32'(CHUNK);
    a_sh    = a_q >> shamt;
    b_sh    = b_q >> shamt;
    chunk_x = a_sh[CHUNK-1:0];
    chunk_y = b_sh[CHUNK-1:0];
    sum_ext = '0;
    sum_ext[CHUNK-1:0] = chunk_sum;
    sum_pos = sum_ext << shamt;
  end

  full_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x_i       (chunk_x),
    .y_i       (chunk_y),
    .ci_i      (carry_q),
    .sum_o     (chunk_sum),
    .co_o      (chunk_co),
    .c_msb_in_o(chunk_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    psum_d  = psum_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          a_d     = a_i;
          // Subtraction is a + ~b + 1; a borrow-in removes that +1.
          b_d     = b_i ^ {WIDTH{sub_i}};
          carry_d = cin_i ^ sub_i;
          idx_d   = '0;
          psum_d  = '0;
        end
      end
      RUN: begin
        // psum is cleared at start, so OR-ing each chunk in is a plain write.
        psum_d  = psum_q | sum_pos;
        carry_d = chunk_co;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
          s_d     = psum_q | sum_pos;
          cout_d  = chunk_co;
          ovf_d   = chunk_cmsb ^ chunk_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      psum_q  <= '0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      psum_q  <= psum_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = done_q;
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder at CHUNK=4 (directed), CHUNK=16 and CHUNK=1 (random sweeps).
// Latency: checked cycle-by-cycle against WIDTH/CHUNK.
// Backpressure: exercises ignored starts while busy and starts in the done cycle.
module tb_multi_cycle_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a_r = '0;
  logic [W-1:0] b_r = '0;
  logic         cin_r = 1'b0;
  logic         sub_r = 1'b0;

  logic         start [3];
  logic         busy  [3];
  logic         done  [3];
  logic [W-1:0] s     [3];
  logic         cout  [3];
  logic         ovf   [3];

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .sub_i(sub_r), .a_i(a_r), .b_i(b_r),
    .cin_i(cin_r), .busy_o(busy[0]), .done_o(done[0]), .s_o(s[0]), .cout_o(cout[0]),
    .ovf_o(ovf[0])
  );

  multi_cycle_adder #(.WIDTH(W), .CHUNK(16)) u_c16 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .sub_i(sub_r), .a_i(a_r), .b_i(b_r),
    .cin_i(cin_r), .busy_o(busy[1]), .done_o(done[1]), .s_o(s[1]), .cout_o(cout[1]),
    .ovf_o(ovf[1])
  );

  multi_cycle_adder #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .sub_i(sub_r), .a_i(a_r), .b_i(b_r),
    .cin_i(cin_r), .busy_o(busy[2]), .done_o(done[2]), .s_o(s[2]), .cout_o(cout[2]),
    .ovf_o(ovf[2])
  );

  function automatic int lat(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Reference: integer arithmetic, cout from range of the unsigned result,
  // ovf from range of the signed result.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    int   ua, ub, sa, sbv, c, us, rs;
    exp_t e;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    c   = ci ? 1 : 0;
    us  = sb ? (ua - ub - c) : (ua + ub + c);
    rs  = sb ? (sa - sbv - c) : (sa + sbv + c);
    e.s = us[W-1:0];
    e.c = sb ? (us >= 0) : (us > 65535);
    e.v = (rs > 32767) || (rs < -32768);
    return e;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation on DUT d, check busy/done every cycle of the expected
  // latency, then pop the scoreboard when done appears. With noise set, start
  // stays high and operands churn for the whole run.
  task automatic run_op(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input bit noise);
    int   n;
    exp_t e;
    n     = lat(d);
    a_r   = a;
    b_r   = b;
    cin_r = ci;
    sub_r = sb;
    start[d] = 1'b1;
    sb_q.push_back(model(a, b, ci, sb));
    tick();
    start[d] = noise;
    for (int j = 0; j < n; j++) begin
      chk("busy_run", d, 32'(busy[d]), 32'd1);
      chk("done_early", d, 32'(done[d]), 32'd0);
      if (noise) begin
        a_r   = 16'($urandom);
        b_r   = 16'($urandom);
        cin_r = 1'($urandom);
        sub_r = 1'($urandom);
      end
      tick();
    end
    start[d] = 1'b0;
    chk("done_pulse", d, 32'(done[d]), 32'd1);
    chk("busy_end", d, 32'(busy[d]), 32'd0);
    if (done[d] && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sum", d, 32'(s[d]), 32'(e.s));
      chk("cout", d, 32'(cout[d]), 32'(e.c));
      chk("ovf", d, 32'(ovf[d]), 32'(e.v));
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_done", i, 32'(done[i]), 32'd0);
      chk("rst_s", i, 32'(s[i]), 32'd0);
      chk("rst_cout", i, 32'(cout[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf[i]), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    tick();
    chk("idle_after_rst", 0, 32'(busy[0]), 32'd0);

    // Directed arithmetic on the CHUNK=4 instance.
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op(0, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0);

    // Starts during RUN and operand churn must not disturb the result or queue work.
    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    tick();
    chk("no_queued_op", 0, 32'(busy[0]), 32'd0);
    chk("done_cleared", 0, 32'(done[0]), 32'd0);

    // Second start issued in the done cycle of the first.
    run_op(0, 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0);
    run_op(0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b0);

    // Reset on the second RUN edge discards the operation.
    a_r = 16'h1111;
    b_r = 16'h2222;
    cin_r = 1'b0;
    sub_r = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_done", 0, 32'(done[0]), 32'd0);
    chk("midrst_s", 0, 32'(s[0]), 32'd0);
    chk("midrst_cout", 0, 32'(cout[0]), 32'd0);
    chk("midrst_ovf", 0, 32'(ovf[0]), 32'd0);
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("midrst_no_done", 0, 32'(done[0]), 32'd0);
    end

    // Random vectors on all three chunk sizes.
    for (int k = 0; k < 200; k++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int k = 0; k < 1000; k++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    for (int k = 0; k < 1000; k++)
      run_op(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
